// File: rtl/alu_op_sequencer.sv
// Command-queue sequencer for a 32-bit combinational ALU: FIFO-buffered commands, one issue at a time,
// registered responses on a valid/ready channel. Define ALU_SEQ_STATS_EN to add response/overflow counters.
module alu_op_sequencer #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_op,
  input  logic        cmd_chain,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  output logic        alu_enable,
  output logic [3:0]  alu_select,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_result,
  input  logic [3:0]  alu_overflow,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [3:0]  rsp_op,
  output logic [31:0] rsp_result,
  output logic        rsp_flag,
`ifdef ALU_SEQ_STATS_EN
  output logic [15:0] stat_done,
  output logic [15:0] stat_ovf,
`endif
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  typedef struct packed {
    logic [3:0]  op;
    logic        chain;
    logic [31:0] a;
    logic [31:0] b;
  } cmd_t;

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  state_t      state, state_next;
  cmd_t        fifo_mem [DEPTH];
  cmd_t        head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count, count_next;
  logic        cmd_ready_q;
  logic        push, pop, fifo_empty;
  logic [31:0] acc;
  logic        flag_sel;

  assign push       = cmd_valid && cmd_ready_q;
  assign fifo_empty = (count == '0);
  assign head       = fifo_mem[rd_ptr];

  // NOTE: the FIFO storage has no reset; the pointers and count alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= '{op: cmd_op, chain: cmd_chain, a: cmd_a, b: cmd_b};
  end

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves a latch behind.
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // cmd_ready is registered from the next count, so a pop from a full FIFO raises it one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      cmd_ready_q <= 1'b1;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count       <= count_next;
      cmd_ready_q <= (count_next != FULL_CNT);
    end
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = EXEC;
        end
      end
      EXEC: state_next = RESP;
      RESP: begin
        if (rsp_ready) begin
          if (!fifo_empty) begin
            pop        = 1'b1;
            state_next = EXEC;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    flag_sel = 1'b0;
    case (alu_select)
      4'd0:    flag_sel = alu_overflow[0];
      4'd1:    flag_sel = alu_overflow[1];
      4'd13:   flag_sel = alu_overflow[2];
      4'd14:   flag_sel = alu_overflow[3];
      default: flag_sel = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      alu_select <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      acc        <= '0;
      rsp_op     <= '0;
      rsp_result <= '0;
      rsp_flag   <= 1'b0;
    end else begin
      state <= state_next;
      if (pop) begin
        // Chained commands take the last completed result as operand A.
        alu_select <= head.op;
        alu_a      <= head.chain ? acc : head.a;
        alu_b      <= head.b;
      end
      if (state == EXEC) begin
        acc        <= alu_result;
        rsp_result <= alu_result;
        rsp_op     <= alu_select;
        rsp_flag   <= flag_sel;
      end
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign alu_enable = (state == EXEC);
  assign rsp_valid  = (state == RESP);
  assign busy       = !fifo_empty || (state != IDLE);

`ifdef ALU_SEQ_STATS_EN
  logic rsp_fire;
  assign rsp_fire = rsp_valid && rsp_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_done <= '0;
      stat_ovf  <= '0;
    end else if (rsp_fire) begin
      if (stat_done != 16'hFFFF)            stat_done <= stat_done + 1'b1;
      if (rsp_flag && stat_ovf != 16'hFFFF) stat_ovf  <= stat_ovf + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: bench-side ALU, queue-based response model, directed and random traffic.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_chain;
  logic [3:0]  cmd_op;
  logic [31:0] cmd_a, cmd_b;
  logic        alu_enable;
  logic [3:0]  alu_select, alu_overflow;
  logic [31:0] alu_a, alu_b, alu_result;
  logic        rsp_valid, rsp_ready, rsp_flag, busy;
  logic [3:0]  rsp_op;
  logic [31:0] rsp_result;
`ifdef ALU_SEQ_STATS_EN
  logic [15:0] stat_done, stat_ovf;
`endif

  alu_op_sequencer #(.DEPTH(4), .AW(2)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_chain(cmd_chain),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_enable(alu_enable), .alu_select(alu_select), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_overflow(alu_overflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_op(rsp_op),
    .rsp_result(rsp_result), .rsp_flag(rsp_flag),
`ifdef ALU_SEQ_STATS_EN
    .stat_done(stat_done), .stat_ovf(stat_ovf),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] result;
    logic        flag;
  } rsp_t;

  rsp_t        exp_q[$];
  int          hs_times[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          hs_cnt   = 0;
  int          done_m   = 0;
  int          ovf_m    = 0;
  logic [31:0] acc_m    = '0;
  logic [31:0] last_result = '0;
  logic        last_flag   = 1'b0;
  bit          rand_done;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Bench ALU: every flag is computed in parallel regardless of the select code.
  function automatic logic [35:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    logic [63:0] prod;
    logic [31:0] r;
    sum  = {1'b0, a} + {1'b0, b};
    prod = {32'b0, a} * {32'b0, b};
    case (op)
      4'd0, 4'd13: r = sum[31:0];
      4'd1:  r = a - b;
      4'd2:  r = a & b;
      4'd3:  r = a | b;
      4'd4:  r = ~a;
      4'd5:  r = a ^ b;
      4'd6:  r = a << b[4:0];
      4'd7:  r = a >> b[4:0];
      4'd8:  r = 32'($signed(a) >>> b[4:0]);
      4'd9:  r = a + 32'd1;
      4'd10: r = a - 32'd1;
      4'd11: r = b;
      4'd12: r = ~(a & b);
      4'd14: r = prod[31:0];
      default: r = (a < b) ? 32'd1 : 32'd0;
    endcase
    return {prod[63:32] != 32'd0, sum[32], a < b, sum[32], r};
  endfunction

  function automatic logic flag_of(input logic [3:0] op, input logic [3:0] ovf);
    case (op)
      4'd0:    return ovf[0];
      4'd1:    return ovf[1];
      4'd13:   return ovf[2];
      4'd14:   return ovf[3];
      default: return 1'b0;
    endcase
  endfunction

  always_comb {alu_overflow, alu_result} = alu_fn(alu_select, alu_a, alu_b);

  always @(posedge clk) cyc <= cyc + 1;

  // Model: at each negedge, predict handshakes that the next rising edge will complete.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      acc_m  = '0;
      done_m = 0;
      ovf_m  = 0;
    end else begin
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          check("rsp_spurious", exp_q.size(), 1);
        end else begin
          check("rsp_op", rsp_op, exp_q[0].op);
          check("rsp_result", rsp_result, exp_q[0].result);
          check("rsp_flag", rsp_flag, exp_q[0].flag);
          if (rsp_ready) begin
            last_result = rsp_result;
            last_flag   = rsp_flag;
            hs_cnt++;
            hs_times.push_back(cyc);
            if (done_m < 65535) done_m++;
            if (exp_q[0].flag && ovf_m < 65535) ovf_m++;
            void'(exp_q.pop_front());
          end
        end
      end
      if (cmd_valid && cmd_ready) begin
        logic [35:0] v;
        v = alu_fn(cmd_op, cmd_chain ? acc_m : cmd_a, cmd_b);
        acc_m = v[31:0];
        exp_q.push_back('{op: cmd_op, result: v[31:0], flag: flag_of(cmd_op, v[35:32])});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] op, input logic ch, input logic [31:0] a, input logic [31:0] b);
    logic rdy;
    int   n;
    cmd_op = op; cmd_chain = ch; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
    n = 0;
    do begin
      rdy = cmd_ready;
      step();
      n++;
    end while (!rdy && n < 300);
    if (!rdy) check("push_timeout", cmd_ready, 1);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || rsp_valid || exp_q.size() != 0) && n < 500) begin
      step();
      n++;
    end
    if (n >= 500) check("idle_timeout", busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int snap;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_chain = 1'b0; cmd_a = '0; cmd_b = '0;
    rsp_ready = 1'b0; rand_done = 1'b0;
    #2;
    check("reset_cmd_ready", cmd_ready, 1);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_alu_enable", alu_enable, 0);
    check("reset_rsp_result", rsp_result, 0);
    @(posedge clk); step();
    rst = 1'b0;

    // Add: latency and busy fall.
    rsp_ready = 1'b1;
    push(4'd0, 1'b0, 32'd5, 32'd7);
    check("lat_valid_n", rsp_valid, 0);
    step();
    check("lat_exec_enable", alu_enable, 1);
    check("lat_valid_n1", rsp_valid, 0);
    step();
    check("lat_valid_n2", rsp_valid, 1);
    check("add_result", rsp_result, 32'd12);
    step();
    check("add_busy_fall", busy, 0);
    check("add_alu_enable_off", alu_enable, 0);
    check("alu_a_held", alu_a, 32'd5);

    // Chaining through the accumulator.
    push(4'd0, 1'b0, 32'hFFFF_FFFF, 32'd1);
    push(4'd13, 1'b1, 32'h1234_5678, 32'd1);
    wait_idle();
    check("chain_result", last_result, 32'd1);

    // Backpressure: four queued plus one held in RESP fills the block.
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(4'd9, 1'b0, 32'(i * 100), 32'd0);
    check("bp_full_ready", cmd_ready, 0);
    check("bp_rsp_valid", rsp_valid, 1);
    cmd_op = 4'd9; cmd_chain = 1'b0; cmd_a = 32'd500; cmd_b = 32'd0; cmd_valid = 1'b1;
    for (int i = 0; i < 3; i++) step();
    check("bp_still_full", cmd_ready, 0);
    rsp_ready = 1'b1;
    push(4'd9, 1'b0, 32'd500, 32'd0);
    wait_idle();
    check("bp_last_result", last_result, 32'd501);

    // Back-to-back responses at 2-cycle spacing.
    hs_times.delete();
    push(4'd2, 1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    push(4'd3, 1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    push(4'd5, 1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    wait_idle();
    check("b2b_count", hs_times.size(), 3);
    if (hs_times.size() == 3) begin
      check("b2b_gap0", hs_times[1] - hs_times[0], 2);
      check("b2b_gap1", hs_times[2] - hs_times[1], 2);
    end
    check("b2b_last", last_result, 32'hFF00_FF00);

    // Reset during EXEC with two entries still queued.
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(4'd11, 1'b0, 32'd0, 32'(i + 40));
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check("rst_mid_exec", alu_enable, 1);
    rst = 1'b1;
    #1;
    check("rst_mid_rsp_valid", rsp_valid, 0);
    check("rst_mid_cmd_ready", cmd_ready, 1);
    check("rst_mid_busy", busy, 0);
    @(posedge clk); step();
    rst = 1'b0;
    snap = hs_cnt;
    rsp_ready = 1'b1;
    push(4'd0, 1'b0 | 1'b1, 32'hDEAD_BEEF, 32'd3);
    wait_idle();
    check("rst_chain_result", last_result, 32'd3);
    check("rst_no_stale", hs_cnt - snap, 1);

    // Op 15 and an unmapped op whose ALU flags are nonzero.
    push(4'd15, 1'b0, 32'd1, 32'd2);
    wait_idle();
    check("op15_result", last_result, 32'd1);
    check("op15_flag", last_flag, 0);
    push(4'd4, 1'b0, 32'd0, 32'd1);
    step(); step();
    check("op4_ovf_nonzero", alu_overflow != 4'd0, 1);
    wait_idle();
    check("op4_result", last_result, 32'hFFFF_FFFF);
    check("op4_flag", last_flag, 0);

    // Random traffic with random response backpressure.
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          logic [31:0] ra, rb;
          ra = $urandom();
          rb = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom();
          push(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), ra, rb);
          repeat ($urandom_range(0, 2)) step();
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          rsp_ready = 1'($urandom_range(0, 1));
          step();
        end
      end
    join
    rsp_ready = 1'b1;
    wait_idle();
    check("rand_drained", exp_q.size(), 0);

`ifdef ALU_SEQ_STATS_EN
    check("stat_done", stat_done, 32'(done_m));
    check("stat_ovf", stat_ovf, 32'(ovf_m));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
